// File: rtl/starflux_pkg.sv
// Shared grid geometry, scheduler state encoding and entity-id typing for the
// collision path.
package starflux_pkg;

  localparam int GRID_W   = 160;
  localparam int GRID_H   = 120;
  localparam int ADDR_W   = 15;
  localparam int HIT_ID_W = 4;

  typedef logic [HIT_ID_W-1:0] hit_id_t;

  localparam hit_id_t ID_USER = '0;

  typedef enum logic [2:0] {
    IDLE,
    SNAP,
    ISSUE,
    CHECK,
    REPORT,
    DONE
  } sched_state_t;

endpackage

// File: rtl/collision_addr_gen.sv
// Maps an entity position onto a grid cell address. The grid writer uses the
// same block so both sides agree on the cell layout.
module collision_addr_gen #(
  parameter int GRID_W = starflux_pkg::GRID_W,
  parameter int GRID_H = starflux_pkg::GRID_H,
  parameter int ADDR_W = starflux_pkg::ADDR_W
) (
  input  logic [7:0]        x,
  input  logic [6:0]        y,
  input  logic              is_user,
  output logic [ADDR_W-1:0] addr,
  output logic              in_range
);
  import starflux_pkg::*;

  localparam logic [ADDR_W-1:0] COL_STRIDE = ADDR_W'(GRID_H);
  localparam logic [ADDR_W-1:0] ROW_TOP    = ADDR_W'(GRID_H - 1);

  logic [ADDR_W-1:0] row_off;

  // The user row is stored flipped relative to screen orientation.
  always_comb begin
    row_off  = is_user ? (ROW_TOP - ADDR_W'(y)) : ADDR_W'(y);
    addr     = (COL_STRIDE * ADDR_W'(x)) + row_off;
    in_range = (32'(x) < 32'(GRID_W)) && (32'(y) < 32'(GRID_H));
  end

endmodule

// File: rtl/collision_scheduler.sv
// Per-frame collision scan: snapshots entity positions, probes the shared
// occupancy grid once per live entity and reports hits over valid/ready.
module collision_scheduler #(
  parameter int NUM_ENEMIES = 4,
  parameter int GRID_W      = starflux_pkg::GRID_W,
  parameter int GRID_H      = starflux_pkg::GRID_H,
  parameter int ADDR_W      = starflux_pkg::ADDR_W
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     start_game_en,
  input  logic                     frame_tick,
  input  logic [7:0]               user_x,
  input  logic [6:0]               user_y,
  input  logic [8*NUM_ENEMIES-1:0] enemy_x,
  input  logic [7*NUM_ENEMIES-1:0] enemy_y,
  input  logic [NUM_ENEMIES-1:0]   enemy_alive,
  output logic                     grid_rd_en,
  output logic [ADDR_W-1:0]        grid_rd_addr,
  input  logic                     grid_rd_data,
  output logic                     hit_valid,
  input  logic                     hit_ready,
  output logic [3:0]               hit_id,
  output logic                     score_pulse,
  output logic                     health_pulse,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overrun
);
  import starflux_pkg::*;

  localparam hit_id_t LAST_ID = hit_id_t'(NUM_ENEMIES);

  sched_state_t state_reg, state_next;
  hit_id_t      idx_reg, idx_next;
  hit_id_t      hit_id_reg, hit_id_next;
  logic         score_pulse_reg, score_pulse_next;
  logic         health_pulse_reg, health_pulse_next;
  logic         overrun_reg, overrun_next;
  logic         snap_load;
  logic         rd_fire;
  logic         advance;

  logic [7:0]   user_x_reg;
  logic [6:0]   user_y_reg;
  logic [7:0]   enemy_x_reg [NUM_ENEMIES];
  logic [6:0]   enemy_y_reg [NUM_ENEMIES];
  logic         alive_reg   [NUM_ENEMIES];

  logic [7:0]        cur_x;
  logic [6:0]        cur_y;
  logic              cur_alive;
  logic              cur_is_user;
  logic              cur_in_range;
  logic              cur_valid;
  logic [ADDR_W-1:0] cur_addr;

  genvar gi;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      user_x_reg <= '0;
      user_y_reg <= '0;
    end else if (snap_load) begin
      user_x_reg <= user_x;
      user_y_reg <= user_y;
    end
  end

  generate
    for (gi = 0; gi < NUM_ENEMIES; gi++) begin : g_enemy_snap
      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          enemy_x_reg[gi] <= '0;
          enemy_y_reg[gi] <= '0;
          alive_reg[gi]   <= 1'b0;
        end else if (snap_load) begin
          enemy_x_reg[gi] <= enemy_x[8*gi +: 8];
          enemy_y_reg[gi] <= enemy_y[7*gi +: 7];
          alive_reg[gi]   <= enemy_alive[gi];
        end
      end
    end
  endgenerate

  // idx 0 selects the user, idx i+1 selects enemy slot i.
  always_comb begin
    cur_is_user = (idx_reg == ID_USER);
    cur_x       = user_x_reg;
    cur_y       = user_y_reg;
    cur_alive   = 1'b1;
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      if (idx_reg == hit_id_t'(i + 1)) begin
        cur_x     = enemy_x_reg[i];
        cur_y     = enemy_y_reg[i];
        cur_alive = alive_reg[i];
      end
    end
  end

  collision_addr_gen #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .x        (cur_x),
    .y        (cur_y),
    .is_user  (cur_is_user),
    .addr     (cur_addr),
    .in_range (cur_in_range)
  );

  assign cur_valid = cur_alive && cur_in_range;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg        <= IDLE;
      idx_reg          <= '0;
      hit_id_reg       <= '0;
      score_pulse_reg  <= 1'b0;
      health_pulse_reg <= 1'b0;
      overrun_reg      <= 1'b0;
    end else begin
      state_reg        <= state_next;
      idx_reg          <= idx_next;
      hit_id_reg       <= hit_id_next;
      score_pulse_reg  <= score_pulse_next;
      health_pulse_reg <= health_pulse_next;
      overrun_reg      <= overrun_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    idx_next          = idx_reg;
    hit_id_next       = hit_id_reg;
    score_pulse_next  = 1'b0;
    health_pulse_next = 1'b0;
    snap_load         = 1'b0;
    rd_fire           = 1'b0;
    advance           = 1'b0;

    case (state_reg)
      IDLE:   if (frame_tick) state_next = SNAP;
      SNAP: begin
        snap_load  = 1'b1;
        idx_next   = ID_USER;
        state_next = ISSUE;
      end
      ISSUE: begin
        if (cur_valid) begin
          rd_fire    = 1'b1;
          state_next = CHECK;
        end else begin
          advance = 1'b1;
        end
      end
      CHECK: begin
        if (grid_rd_data) begin
          hit_id_next = idx_reg;
          state_next  = REPORT;
        end else begin
          advance = 1'b1;
        end
      end
      REPORT: begin
        if (hit_ready) begin
          score_pulse_next  = (idx_reg != ID_USER);
          health_pulse_next = (idx_reg == ID_USER);
          advance           = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (advance) begin
      if (idx_reg == LAST_ID) begin
        state_next = DONE;
      end else begin
        idx_next   = idx_reg + hit_id_t'(1);
        state_next = ISSUE;
      end
    end

    // Losing the game enable overrides everything, including an accept.
    if (!start_game_en) begin
      state_next        = IDLE;
      score_pulse_next  = 1'b0;
      health_pulse_next = 1'b0;
      rd_fire           = 1'b0;
    end
  end

  always_comb begin
    overrun_next = overrun_reg;
    if (!start_game_en) begin
      overrun_next = 1'b0;
    end else if (frame_tick && (state_reg != IDLE)) begin
      overrun_next = 1'b1;
    end
  end

  assign grid_rd_en   = rd_fire;
  assign grid_rd_addr = rd_fire ? cur_addr : '0;
  assign hit_valid    = (state_reg == REPORT);
  assign hit_id       = hit_id_reg;
  assign score_pulse  = score_pulse_reg;
  assign health_pulse = health_pulse_reg;
  assign busy         = (state_reg != IDLE);
  assign frame_done   = (state_reg == DONE) && start_game_en;
  assign overrun      = overrun_reg;

endmodule

// File: tb/tb_collision_scheduler.sv
// Directed and randomised frame scans with a grid model and a scoreboard of
// expected reads, hits, pulses and frame_done timing.
module tb_collision_scheduler;

  localparam int NE = 4;

  logic          clock;
  logic          resetn;
  logic          start_game_en;
  logic          frame_tick;
  logic [7:0]    user_x;
  logic [6:0]    user_y;
  logic [8*NE-1:0] enemy_x;
  logic [7*NE-1:0] enemy_y;
  logic [NE-1:0] enemy_alive;
  logic          grid_rd_en;
  logic [14:0]   grid_rd_addr;
  logic          grid_rd_data;
  logic          hit_valid;
  logic          hit_ready;
  logic [3:0]    hit_id;
  logic          score_pulse;
  logic          health_pulse;
  logic          busy;
  logic          frame_done;
  logic          overrun;

  collision_scheduler #(.NUM_ENEMIES(NE)) dut (
    .clock         (clock),
    .resetn        (resetn),
    .start_game_en (start_game_en),
    .frame_tick    (frame_tick),
    .user_x        (user_x),
    .user_y        (user_y),
    .enemy_x       (enemy_x),
    .enemy_y       (enemy_y),
    .enemy_alive   (enemy_alive),
    .grid_rd_en    (grid_rd_en),
    .grid_rd_addr  (grid_rd_addr),
    .grid_rd_data  (grid_rd_data),
    .hit_valid     (hit_valid),
    .hit_ready     (hit_ready),
    .hit_id        (hit_id),
    .score_pulse   (score_pulse),
    .health_pulse  (health_pulse),
    .busy          (busy),
    .frame_done    (frame_done),
    .overrun       (overrun)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  bit grid_mem [0:32767];

  int exp_rd_addr[$];
  int exp_rd_edge[$];
  int exp_done_edge[$];
  int exp_hit_id[$];
  int exp_health_total = 0;
  int exp_score_total = 0;
  int health_cnt = 0;
  int score_cnt = 0;
  int valid_cycles = 0;
  int touched[$];

  bit         pend_sc, pend_hl;
  logic       prev_v, prev_r, prev_en;
  logic [3:0] prev_id;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Single-port grid with one cycle of read latency.
  always @(posedge clock) grid_rd_data <= grid_rd_en && grid_mem[grid_rd_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!resetn) begin
      pend_sc = 1'b0;
      pend_hl = 1'b0;
      prev_v  = 1'b0;
    end else begin
      if (score_pulse || pend_sc) check("score_pulse", 32'(score_pulse), 32'(pend_sc));
      if (health_pulse || pend_hl) check("health_pulse", 32'(health_pulse), 32'(pend_hl));
      if (score_pulse) score_cnt++;
      if (health_pulse) health_cnt++;
      pend_sc = 1'b0;
      pend_hl = 1'b0;
      if (prev_v && !prev_r && prev_en) begin
        check("valid_hold", 32'(hit_valid), 1);
        check("id_hold", 32'(hit_id), 32'(prev_id));
      end
      if (hit_valid) valid_cycles++;
      if (grid_rd_en) begin
        check("rd_expected", 32'(exp_rd_addr.size() != 0), 1);
        if (exp_rd_addr.size() != 0) begin
          check("rd_addr", 32'(grid_rd_addr), exp_rd_addr.pop_front());
          check("rd_edge", cyc + 1, exp_rd_edge.pop_front());
        end
      end
      if (frame_done) begin
        check("done_expected", 32'(exp_done_edge.size() != 0), 1);
        if (exp_done_edge.size() != 0) check("done_edge", cyc + 1, exp_done_edge.pop_front());
      end
      if (hit_valid && hit_ready && start_game_en) begin
        check("hit_expected", 32'(exp_hit_id.size() != 0), 1);
        if (exp_hit_id.size() != 0) begin
          int id;
          id = exp_hit_id.pop_front();
          check("hit_id", 32'(hit_id), id);
          pend_hl = (id == 0);
          pend_sc = (id != 0);
        end
      end
      prev_v  = hit_valid;
      prev_r  = hit_ready;
      prev_en = start_game_en;
      prev_id = hit_id;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Timing model: first ISSUE sampled at k+2; skip=1 cycle, read=2, hit adds REPORT cycles.
  task automatic plan_scan(input int k, input int stall);
    int cur, x, y, a;
    bit ok;
    cur = k + 2;
    for (int e = 0; e <= NE; e++) begin
      if (e == 0) begin
        x = int'(user_x); y = int'(user_y); ok = 1'b1; a = 120 * x + 119 - y;
      end else begin
        x = int'(enemy_x[8*(e-1) +: 8]); y = int'(enemy_y[7*(e-1) +: 7]);
        ok = enemy_alive[e-1]; a = 120 * x + y;
      end
      ok = ok && (x < 160) && (y < 120);
      if (!ok) begin
        cur += 1;
      end else begin
        exp_rd_addr.push_back(a);
        exp_rd_edge.push_back(cur);
        if (grid_mem[a]) begin
          exp_hit_id.push_back(e);
          if (e == 0) exp_health_total++; else exp_score_total++;
          cur += 3 + stall;
        end else begin
          cur += 2;
        end
      end
    end
    exp_done_edge.push_back(cur);
  endtask

  task automatic start_scan(input int stall);
    frame_tick = 1'b1;
    plan_scan(cyc + 1, stall);
    step();
    frame_tick = 1'b0;
  endtask

  task automatic wait_scan(input string tag);
    int n;
    n = 0;
    while (exp_done_edge.size() != 0 && n < 500) begin
      step();
      n++;
    end
    check({tag, "_in_time"}, 32'(n < 500), 1);
    check({tag, "_reads_left"}, exp_rd_addr.size(), 0);
    check({tag, "_hits_left"}, exp_hit_id.size(), 0);
    check({tag, "_idle"}, 32'(busy), 0);
  endtask

  task automatic flush();
    exp_rd_addr.delete();
    exp_rd_edge.delete();
    exp_done_edge.delete();
    exp_hit_id.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"}, 32'(grid_rd_en), 0);
    check({tag, "_rd_addr"}, 32'(grid_rd_addr), 0);
    check({tag, "_hit_valid"}, 32'(hit_valid), 0);
    check({tag, "_hit_id"}, 32'(hit_id), 0);
    check({tag, "_score"}, 32'(score_pulse), 0);
    check({tag, "_health"}, 32'(health_pulse), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(frame_done), 0);
    check({tag, "_overrun"}, 32'(overrun), 0);
  endtask

  task automatic set_default_pos();
    user_x = 8'd10; user_y = 7'd20;
    enemy_x = {8'd4, 8'd5, 8'd2, 8'd1};
    enemy_y = {7'd4, 7'd7, 7'd2, 7'd1};
    enemy_alive = 4'b1111;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, h0, s0, v0, a;
    resetn = 1'b0; start_game_en = 1'b0; frame_tick = 1'b0; hit_ready = 1'b1;
    set_default_pos();
    for (int i = 0; i < 32768; i++) grid_mem[i] = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    resetn = 1'b1; start_game_en = 1'b1;
    step();

    // No hits: 5 reads at k+2..k+10, frame_done at k+12.
    start_scan(0);
    wait_scan("nohit");

    // User hit at cell 1299 with ready tied high.
    grid_mem[1299] = 1'b1;
    h0 = health_cnt; s0 = score_cnt;
    start_scan(0);
    wait_scan("userhit");
    check("userhit_health", health_cnt - h0, 1);
    check("userhit_score", score_cnt - s0, 0);
    grid_mem[1299] = 1'b0;

    // Enemy 2 hit at cell 607 held off for 10 cycles.
    grid_mem[607] = 1'b1;
    hit_ready = 1'b0;
    s0 = score_cnt; v0 = valid_cycles;
    start_scan(10);
    n = 0;
    while (!hit_valid && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("bp_valid_seen", 32'(hit_valid), 1);
    check("bp_hit_id", 32'(hit_id), 3);
    repeat (10) @(posedge clock);
    #1;
    hit_ready = 1'b1;
    wait_scan("backpressure");
    check("bp_score", score_cnt - s0, 1);
    check("bp_valid_cycles", valid_cycles - v0, 11);
    grid_mem[607] = 1'b0;

    // Skips: dead slots 1 and 3, slot 0 off-grid.
    enemy_alive = 4'b0101;
    enemy_x[7:0] = 8'd170;
    start_scan(0);
    wait_scan("skip");
    set_default_pos();

    // Asynchronous reset in the middle of a scan.
    start_scan(0);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("arst_busy_pre", 32'(busy), 1);
    check("arst_overrun_pre", 32'(overrun), 1);
    #2;
    resetn = 1'b0;
    #1;
    check_all_zero("arst");
    flush();
    step();
    step();
    resetn = 1'b1;
    step();
    start_scan(0);
    wait_scan("post_arst");

    // Overrun: a second tick mid-scan is dropped and the scan completes.
    check("overrun_pre", 32'(overrun), 0);
    start_scan(0);
    repeat (3) step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    wait_scan("overrun");
    check("overrun_set", 32'(overrun), 1);

    // Abort during REPORT, with ready arriving in the same cycle.
    grid_mem[1299] = 1'b1;
    hit_ready = 1'b0;
    start_scan(0);
    n = 0;
    while (!hit_valid && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("abort_valid_seen", 32'(hit_valid), 1);
    step();
    start_game_en = 1'b0;
    hit_ready = 1'b1;
    step();
    check("abort_hit_valid", 32'(hit_valid), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_overrun", 32'(overrun), 0);
    check("abort_hit_pending", exp_hit_id.size(), 1);
    flush();
    exp_health_total--;
    repeat (3) step();
    grid_mem[1299] = 1'b0;
    start_game_en = 1'b1;
    step();

    // Randomised frames with random hits, skips and off-grid positions.
    for (int f = 0; f < 6; f++) begin
      user_x = 8'($urandom_range(0, 165));
      user_y = 7'($urandom_range(0, 125));
      for (int i = 0; i < NE; i++) begin
        enemy_x[8*i +: 8] = 8'($urandom_range(0, 165));
        enemy_y[7*i +: 7] = 7'($urandom_range(0, 125));
      end
      enemy_alive = 4'($urandom_range(0, 15));
      if (user_x < 160 && user_y < 120 && $urandom_range(0, 1) == 1) begin
        a = 120 * int'(user_x) + 119 - int'(user_y);
        grid_mem[a] = 1'b1;
        touched.push_back(a);
      end
      for (int i = 0; i < NE; i++) begin
        if (enemy_x[8*i +: 8] < 160 && enemy_y[7*i +: 7] < 120 && $urandom_range(0, 1) == 1) begin
          a = 120 * int'(enemy_x[8*i +: 8]) + int'(enemy_y[7*i +: 7]);
          grid_mem[a] = 1'b1;
          touched.push_back(a);
        end
      end
      start_scan(0);
      wait_scan("random");
      foreach (touched[j]) grid_mem[touched[j]] = 1'b0;
      touched.delete();
    end

    repeat (3) step();
    check("total_health", health_cnt, exp_health_total);
    check("total_score", score_cnt, exp_score_total);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/collision_scheduler.md
Name: collision_scheduler

Overview:
Sequences per-frame collision checks against the shared 160x120 occupancy grid through a single-port, 1-cycle-latency read interface. On each frame tick it snapshots the user and NUM_ENEMIES enemy positions, then reads the grid cell for each live entity in turn. Each hit is reported over a valid/ready event channel, with score and health pulses derived from it. It sits between the game-state FSM (frame tick, game enable) and the score/health counters, and replaces free-running per-entity grid probes.

Parameters:
NUM_ENEMIES, 4, number of enemy slots scanned per frame (1..15)
GRID_W, 160, grid width in cells
GRID_H, 120, grid height in cells
ADDR_W, 15, grid read address width; must satisfy 2^ADDR_W >= GRID_W*GRID_H

Ports:
clock  in  1  system clock; the only clock in the block
resetn  in  1  asynchronous, active-low reset
start_game_en  in  1  game running; low aborts any scan and holds the block idle
frame_tick  in  1  one-cycle pulse requesting a scan
user_x  in  8  user column
user_y  in  7  user row, screen orientation
enemy_x  in  8*NUM_ENEMIES  packed enemy columns; slot i at [8i+7:8i]
enemy_y  in  7*NUM_ENEMIES  packed enemy rows
enemy_alive  in  NUM_ENEMIES  slot-valid mask
grid_rd_en  out  1  grid read strobe
grid_rd_addr  out  ADDR_W  grid read address
grid_rd_data  in  1  cell value, valid the cycle after grid_rd_en
hit_valid  out  1  hit event pending
hit_ready  in  1  consumer accepts event
hit_id  out  4  0 = user, i+1 = enemy slot i
score_pulse  out  1  one cycle on accepted enemy hit
health_pulse  out  1  one cycle on accepted user hit
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse at end of a completed scan
overrun  out  1  sticky; frame_tick arrived while busy

Behaviour:
- Reset (resetn low, async): state IDLE, and every output is 0, including grid_rd_addr and hit_id. Reset is released synchronously.
- States: IDLE, SNAP, ISSUE, CHECK, REPORT, DONE.
- IDLE: on frame_tick && start_game_en, go to SNAP.
- SNAP (1 cycle): register all position inputs and enemy_alive; set idx=0. Inputs are not sampled again until the next SNAP.
- ISSUE: an entity is skipped when it is an enemy with alive=0, or when x>=GRID_W or y>=GRID_H.
  - Skipped entity: no read; advance in this same cycle (1 cycle per skipped entity).
  - Otherwise: assert grid_rd_en for exactly 1 cycle, then go to CHECK.
- Address arithmetic: all addresses are computed in ADDR_W bits, with no truncation for in-range coordinates (max 19199).
  - User: addr = GRID_H*x + (GRID_H-1-y).
  - Enemy: addr = GRID_H*x + y.
- CHECK: sample grid_rd_data. If 1, set hit_id=idx and go to REPORT; otherwise advance.
- REPORT:
  - hit_valid=1, with hit_id stable until accepted.
  - On hit_valid && hit_ready: pulse score_pulse (idx>0) or health_pulse (idx=0) in the next cycle, deassert hit_valid, and advance.
  - There is no timeout; the scan stalls until the event is accepted.
- Advance: if idx==NUM_ENEMIES go to DONE, else idx+1 and go to ISSUE.
- DONE: frame_done=1 for 1 cycle, then IDLE.
- Latency with no hits and all entities valid: frame_tick sampled at edge k gives SNAP at k+1, the first ISSUE at k+2, and frame_done high in cycle k+2+2*(NUM_ENEMIES+1).
- Each entity is reported at most once per frame. Order is fixed: user, then enemy 0..N-1.
- frame_tick while busy: the tick is dropped and overrun is set. overrun clears only on reset or start_game_en low.
- frame_tick in the same cycle as DONE: dropped and counts as overrun. A new scan starts only from IDLE.
- start_game_en low in any state: next state IDLE. hit_valid is withdrawn without acceptance (the only permitted exception to valid stability), no pulses fire, and frame_done does not fire.
- Simultaneous hit_ready with start_game_en low: abort wins and no pulse fires.

Decomposition:
- Package starflux_pkg: GRID_W, GRID_H, ADDR_W constants, the scheduler state enum, and the entity-id width/typedef (HIT_ID_W=4, ID_USER=0).
- Sub-module collision_addr_gen (combinational): inputs x, y, is_user; outputs addr and in_range. It is shared with the grid writer to guarantee identical cell mapping.

Test Plan:
- No hits: NUM_ENEMIES=4, all alive, grid all 0, tick at edge k -> 5 grid_rd_en pulses at k+2, k+4 ... k+10, frame_done at k+12, hit_valid never high.
- User hit: user (10,20), cell 120*10+99=1299 set, hit_ready tied 1 -> grid_rd_addr=1299, hit_valid with hit_id=0 for 1 cycle, health_pulse once, score_pulse never.
- Enemy hit with backpressure: enemy 2 at (5,7), addr 607 set, hit_ready low 10 cycles -> hit_valid and hit_id=3 held stable 10 cycles; no further grid_rd_en until accept; one score_pulse after accept.
- Skips: enemy_alive=4'b0101, enemy 0 at x=170 -> reads only for user and enemy 2; frame_done at k+2+2+1+1+2+1.
- Overrun/abort: second frame_tick mid-scan -> overrun=1 and scan completes normally; then start_game_en low during REPORT -> next cycle IDLE, hit_valid=0, busy=0, overrun=0, no pulse.
- Async reset mid-scan: resetn low between edges -> all outputs 0 immediately; first tick after release yields a full scan.
